ir_key_decoder: RTL

Converts raw 32-bit NEC frames from the infrared receiver into validated, debounced single-cycle key events for the game logic. It sits directly between the IR receiver and the guess-number game core. It checks frame integrity, optionally filters by remote address, maps command bytes to a compact key code and suppresses auto-repeat from held buttons.

---
 rtl/ir_key_pkg.sv | 60 ++++++
 rtl/ir_key_decoder_ms_tick.sv | 29 ++
 rtl/ir_key_decoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ir_key_pkg.sv
// Key codes and NEC command map shared by the IR key decoder.
// cmd_to_key() turns a command byte into a key code plus a "mapped" flag.
`timescale 1ns/1ps
package ir_key_pkg;

    typedef enum logic [3:0] {
        K0    = 4'd0,
        K1    = 4'd1,
        K2    = 4'd2,
        K3    = 4'd3,
        K4    = 4'd4,
        K5    = 4'd5,
        K6    = 4'd6,
        K7    = 4'd7,
        K8    = 4'd8,
        K9    = 4'd9,
        ENTER = 4'd10,
        CLEAR = 4'd11,
        UP    = 4'd12,
        DOWN  = 4'd13
    } key_t;

    localparam logic [7:0] CMD_0     = 8'h16;
    localparam logic [7:0] CMD_1     = 8'h0C;
    localparam logic [7:0] CMD_2     = 8'h18;
    localparam logic [7:0] CMD_3     = 8'h5E;
    localparam logic [7:0] CMD_4     = 8'h08;
    localparam logic [7:0] CMD_5     = 8'h1C;
    localparam logic [7:0] CMD_6     = 8'h5A;
    localparam logic [7:0] CMD_7     = 8'h42;
    localparam logic [7:0] CMD_8     = 8'h52;
    localparam logic [7:0] CMD_9     = 8'h4A;
    localparam logic [7:0] CMD_ENTER = 8'h43;
    localparam logic [7:0] CMD_CLEAR = 8'h09;
    localparam logic [7:0] CMD_UP    = 8'h47;
    localparam logic [7:0] CMD_DOWN  = 8'h45;

    function automatic void cmd_to_key(input logic [7:0] cmd, output key_t key, output logic mapped);
        key    = K0;
        mapped = 1'b1;
        case (cmd)
            CMD_0:     key = K0;
            CMD_1:     key = K1;
            CMD_2:     key = K2;
            CMD_3:     key = K3;
            CMD_4:     key = K4;
            CMD_5:     key = K5;
            CMD_6:     key = K6;
            CMD_7:     key = K7;
            CMD_8:     key = K8;
            CMD_9:     key = K9;
            CMD_ENTER: key = ENTER;
            CMD_CLEAR: key = CLEAR;
            CMD_UP:    key = UP;
            CMD_DOWN:  key = DOWN;
            default:   mapped = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ir_key_decoder_ms_tick.sv
// Free-running millisecond prescaler: TICK pulses for one cycle every CLK_MHZ*1000 cycles.
`timescale 1ns/1ps
module ms_tick #(
    parameter int CLK_MHZ = 50
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int CYCLES = CLK_MHZ * 1000;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign TICK = (count_reg == LAST);

endmodule

// File: rtl/ir_key_decoder.sv
// NEC frame to key-event decoder: capture stage, integrity/filter/map stage,
// auto-repeat holdoff FSM and a saturating reject counter.
`timescale 1ns/1ps
module ir_key_decoder
    import ir_key_pkg::*;
#(
    parameter int         CLK_MHZ    = 50,
    parameter int         HOLDOFF_MS = 200,
    parameter int         ADDR_CHECK = 1,
    parameter logic [7:0] ADDR       = 8'h00
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR_DATA,
    input  logic        IR_DATA_READY,
    input  logic [7:0]  IR_ERROR,
    output logic [3:0]  KEY,
    output logic        KEY_VALID,
    output logic        KEY_IS_DIGIT,
    output logic [7:0]  ERR_CNT
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam int HOLD_W = (HOLDOFF_MS > 0) ? $clog2(HOLDOFF_MS + 1) : 1;

    logic              tick;
    logic              s1_valid_reg;
    logic [31:0]       s1_data_reg;
    logic [7:0]        s1_err_reg;

    logic [0:0]        state_reg, state_next;
    logic [HOLD_W-1:0] hold_ms_reg, hold_ms_next;
    logic [3:0]        last_key_reg, last_key_next;

    logic [3:0]        key_reg;
    logic              key_valid_reg;
    logic              key_is_digit_reg;
    logic [7:0]        err_cnt_reg;

    logic [7:0]        f_addr, f_naddr, f_cmd, f_ncmd;
    key_t              frame_key;
    logic              frame_mapped;
    logic              frame_bad;
    logic              addr_ok;
    logic              accept;
    logic              emit;

    ms_tick #(.CLK_MHZ(CLK_MHZ)) u_ms_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .TICK  (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_err_reg   <= '0;
        end else begin
            s1_valid_reg <= IR_DATA_READY;
            if (IR_DATA_READY) begin
                s1_data_reg <= IR_DATA;
                s1_err_reg  <= IR_ERROR;
            end
        end
    end

    assign f_addr  = s1_data_reg[31:24];
    assign f_naddr = s1_data_reg[23:16];
    assign f_cmd   = s1_data_reg[15:8];
    assign f_ncmd  = s1_data_reg[7:0];

    always_comb begin
        frame_key    = K0;
        frame_mapped = 1'b0;
        cmd_to_key(f_cmd, frame_key, frame_mapped);
    end

    // Integrity failures are counted; address mismatch and unmapped commands are not.
    assign frame_bad = (s1_err_reg != 8'h00) ||
                       ((f_addr ^ f_naddr) != 8'hFF) ||
                       ((f_cmd ^ f_ncmd) != 8'hFF);
    assign addr_ok   = (ADDR_CHECK == 0) || (f_addr == ADDR);
    assign accept    = s1_valid_reg && !frame_bad && addr_ok && frame_mapped;
    assign emit      = accept && ((state_reg == ST_IDLE) || (4'(frame_key) != last_key_reg));

    // An accepted frame always reloads the holdoff, so it takes priority over a coincident tick.
    always_comb begin
        state_next    = state_reg;
        hold_ms_next  = hold_ms_reg;
        last_key_next = last_key_reg;
        if (accept) begin
            state_next    = ST_HOLD;
            hold_ms_next  = HOLD_W'(HOLDOFF_MS);
            last_key_next = 4'(frame_key);
        end else if (tick && (state_reg == ST_HOLD)) begin
            if (hold_ms_reg <= HOLD_W'(1)) begin
                state_next   = ST_IDLE;
                hold_ms_next = '0;
            end else begin
                hold_ms_next = hold_ms_reg - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg        <= ST_IDLE;
            hold_ms_reg      <= '0;
            last_key_reg     <= '0;
            key_reg          <= '0;
            key_valid_reg    <= 1'b0;
            key_is_digit_reg <= 1'b0;
            err_cnt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            hold_ms_reg   <= hold_ms_next;
            last_key_reg  <= last_key_next;
            key_valid_reg <= emit;
            if (emit) begin
                key_reg          <= 4'(frame_key);
                key_is_digit_reg <= (frame_key <= K9);
            end
            if (s1_valid_reg && frame_bad && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign KEY          = key_reg;
    assign KEY_VALID    = key_valid_reg;
    assign KEY_IS_DIGIT = key_is_digit_reg;
    assign ERR_CNT      = err_cnt_reg;

endmodule
